data_sram_resp: RTL and testbench
=================================

DATA_SRAM_RESP -- requirements
Module: data_sram_resp

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, giving the word-index width; depth is 2^ADDR_W 32-bit words.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port data_sram_en, input, 1 bit: access request valid this cycle.
REQ-005 SHALL have port data_sram_wen, input, 4 bits: byte-lane write enables; bit n writes bits 8n+7:8n; all zero means a read.
REQ-006 SHALL have port data_sram_addr, input, 32 bits: byte address.
REQ-007 SHALL have port data_sram_wdata, input, 32 bits: write data.
REQ-008 SHALL have port data_sram_rdata, output, 32 bits: registered read data.
REQ-009 SHALL have port resp_err, output, 1 bit: out-of-range access flag, aligned with data_sram_rdata.
REQ-010 SHALL have port rd_cnt, output, 32 bits: count of accepted reads.
REQ-011 SHALL have port wr_cnt, output, 32 bits: count of accepted writes.

Function
REQ-012 SHALL form the word index from data_sram_addr[ADDR_W+1:2] and ignore addr[1:0].
REQ-013 SHALL treat en=1 with wen=0 as a read, with mem[index] on data_sram_rdata after the next rising edge (1-cycle latency).
REQ-014 SHALL treat en=1 with wen!=0 as a write of only the enabled byte lanes at that edge; disabled lanes keep their values.
REQ-015 SHALL give read-first behaviour on a write: data_sram_rdata after the edge shows the word's pre-write contents.
REQ-016 SHALL make the new data visible to a read of the same word in the cycle after a write (back-to-back write then read).
REQ-017 SHALL hold data_sram_rdata and resp_err at their previous values while en=0.
REQ-018 SHALL increment rd_cnt by 1 per accepted read and wr_cnt by 1 per accepted write; both wrap from 0xFFFFFFFF to 0.
REQ-019 SHALL treat accesses on consecutive cycles as independent, with no bubbles or stalls required; the block never back-pressures.

Reset
REQ-020 SHALL, while rst=1 and regardless of clk, drive data_sram_rdata=0, resp_err=0, rd_cnt=0 and wr_cnt=0.
REQ-021 SHALL perform no write and no counter update at any edge where rst=1, including when en is high mid-operation.
REQ-022 SHALL leave memory contents unreset; pre-reset data survives a reset pulse.
REQ-023 SHALL accept the first access at the first rising edge after rst deasserts.

Configuration
REQ-024 SHALL, when macro DATA_SRAM_RESP_RANGE_CHECK_EN is defined, treat an access with addr[31:ADDR_W+2] != 0 as out-of-range.
REQ-025 SHALL, for an out-of-range access, suppress the write, return data_sram_rdata=0 and set resp_err=1 for that response.
REQ-026 SHALL count an out-of-range access in the matching counter and clear resp_err on the next in-range access.
REQ-027 SHALL, without DATA_SRAM_RESP_RANGE_CHECK_EN, ignore the upper address bits (aliasing) and tie resp_err to 0.

Verification
REQ-028 SHALL pass: write addr 0x10, wen=4'hF, wdata 0xDEADBEEF, then read 0x10 -> rdata=0xDEADBEEF one cycle later, wr_cnt=1, rd_cnt=1.
REQ-029 SHALL pass: after REQ-028, write 0x10 with wen=4'b0101 and wdata 0x11223344, then read -> rdata=0xDE22BE44.
REQ-030 SHALL pass: write 0x20 with 0x0 then 0x20 with 0x5A5A5A5A -> rdata after the second write=0x00000000 (read-first), next read=0x5A5A5A5A.
REQ-031 SHALL pass: pulse rst asynchronously mid-burst between edges -> outputs 0 immediately, the write at a rst-high edge is absent, and earlier memory data is intact.
REQ-032 SHALL pass, with ADDR_W=10 and the macro defined: read 0x00001000 -> rdata=0, resp_err=1; the same access without the macro -> data of word 0, resp_err=0.
REQ-033 SHALL pass: preload rd_cnt near wrap by forcing or by 2^32 reads in simulation, then read -> rd_cnt 0xFFFFFFFF to 0x00000000.

Source files
------------

// File: rtl/data_sram_resp.sv
// Single-port 32-bit data SRAM with byte-lane writes, read-first registered response and access counters.
// Optional feature: define DATA_SRAM_RESP_RANGE_CHECK_EN to flag and block accesses above the array.
module data_sram_resp #(
    parameter int ADDR_W = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        resp_err,
    output logic [31:0] rd_cnt,
    output logic [31:0] wr_cnt
);
    localparam int DEPTH = 1 << ADDR_W;

    // Handshake: data_sram_en is the request valid; the block is always ready, so
    // every cycle with en=1 is accepted and answered one edge later, with no stalls.

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] idx;
    logic              in_range;
    logic              is_rd;
    logic              is_wr;
    logic              unused_addr;

    assign idx   = data_sram_addr[ADDR_W+1:2];
    assign is_rd = data_sram_en && (data_sram_wen == 4'b0000);
    assign is_wr = data_sram_en && (data_sram_wen != 4'b0000);

`ifdef DATA_SRAM_RESP_RANGE_CHECK_EN
    assign in_range = (data_sram_addr[31:ADDR_W+2] == '0);
`else
    // Upper address bits alias onto the array.
    assign in_range = 1'b1;
`endif

    assign unused_addr = ^{data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

    // Storage is deliberately not reset; a write is only blocked while rst is high.
    always_ff @(posedge clk) begin
        if (!rst && is_wr && in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (data_sram_wen[i]) begin
                    mem[idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_sram_rdata <= 32'h0;
            resp_err        <= 1'b0;
            rd_cnt          <= 32'h0;
            wr_cnt          <= 32'h0;
        end else begin
            if (data_sram_en) begin
                // Read-first: a write returns the word as it was before this edge.
                if (in_range) begin
                    data_sram_rdata <= mem[idx];
                    resp_err        <= 1'b0;
                end else begin
                    data_sram_rdata <= 32'h0;
                    resp_err        <= 1'b1;
                end
            end
            if (is_rd) begin
                rd_cnt <= rd_cnt + 32'd1;
            end
            if (is_wr) begin
                wr_cnt <= wr_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_data_sram_resp.sv
// Self-checking bench for data_sram_resp: directed vector table, reset/wrap sequences and a
// randomised phase checked against a shadow-memory model through an expected-response queue.
module tb_data_sram_resp;

    logic        clk;
    logic        rst;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] rd_cnt;
    logic [31:0] wr_cnt;

    int checks;
    int errors;

    data_sram_resp #(.ADDR_W(10)) dut (
        .clk             (clk),
        .rst             (rst),
        .data_sram_en    (en),
        .data_sram_wen   (wen),
        .data_sram_addr  (addr),
        .data_sram_wdata (wdata),
        .data_sram_rdata (rdata),
        .resp_err        (err),
        .rd_cnt          (rd_cnt),
        .wr_cnt          (wr_cnt)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // model state
    logic [31:0] shadow [int];
    bit          known  [int];
    logic [31:0] last_rd;
    logic        last_err;
    logic        last_known;
    logic [31:0] rd_m;
    logic [31:0] wr_m;

    // scoreboard: {chk, err, rdata}
    logic [33:0] exp_q [$];

    typedef struct {
        logic        en;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_oor(input logic [31:0] a);
`ifdef DATA_SRAM_RESP_RANGE_CHECK_EN
        return (a[31:12] != 20'h0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [33:0] predict(input logic e, input logic [31:0] a);
        int i;
        i = int'(a[11:2]);
        if (!e) return {last_known, last_err, last_rd};
        if (model_oor(a)) return {1'b1, 1'b1, 32'h0};
        return {known.exists(i) && known[i], 1'b0, shadow.exists(i) ? shadow[i] : 32'h0};
    endfunction

    // driver: called at a negedge, returns at the following negedge after checking
    task automatic do_cycle(input logic e, input logic [3:0] w, input logic [31:0] a,
                            input logic [31:0] d, input logic [33:0] expv);
        logic [33:0] got;
        int          i;
        en    = e;
        wen   = w;
        addr  = a;
        wdata = d;
        exp_q.push_back(expv);
        if (e) begin
            last_known = expv[33];
            last_err   = expv[32];
            last_rd    = expv[31:0];
            if (w == 4'h0) rd_m = rd_m + 32'd1;
            else           wr_m = wr_m + 32'd1;
            if (w != 4'h0 && !model_oor(a)) begin
                i = int'(a[11:2]);
                if (!shadow.exists(i)) shadow[i] = 32'h0;
                for (int b = 0; b < 4; b++)
                    if (w[b]) shadow[i][8*b +: 8] = d[8*b +: 8];
                if (w == 4'hF) known[i] = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        got = exp_q.pop_front();
        if (got[33]) begin
            check("rdata", rdata, got[31:0]);
            check("resp_err", {31'h0, err}, {31'h0, got[32]});
        end
        check("rd_cnt", rd_cnt, rd_m);
        check("wr_cnt", wr_cnt, wr_m);
    endtask

    task automatic model_access(input logic e, input logic [3:0] w, input logic [31:0] a,
                                input logic [31:0] d);
        do_cycle(e, w, a, d, predict(e, a));
    endtask

    task automatic model_reset();
        last_rd    = 32'h0;
        last_err   = 1'b0;
        last_known = 1'b1;
        rd_m       = 32'h0;
        wr_m       = 32'h0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        en = 1'b0;
        wen = 4'h0;
        addr = 32'h0;
        wdata = 32'h0;
        model_reset();

        vecs[0]  = '{1'b1, 4'hF, 32'h10,   32'hDEADBEEF, 1'b0, 32'h0,        1'b0};
        vecs[1]  = '{1'b1, 4'h0, 32'h10,   32'h0,        1'b1, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 4'h5, 32'h10,   32'h11223344, 1'b1, 32'hDEADBEEF, 1'b0};
        vecs[3]  = '{1'b1, 4'h0, 32'h10,   32'h0,        1'b1, 32'hDE22BE44, 1'b0};
        vecs[4]  = '{1'b0, 4'h0, 32'h10,   32'h0,        1'b1, 32'hDE22BE44, 1'b0};
        vecs[5]  = '{1'b1, 4'hF, 32'h20,   32'h0,        1'b0, 32'h0,        1'b0};
        vecs[6]  = '{1'b1, 4'hF, 32'h20,   32'h5A5A5A5A, 1'b1, 32'h00000000, 1'b0};
        vecs[7]  = '{1'b1, 4'h0, 32'h20,   32'h0,        1'b1, 32'h5A5A5A5A, 1'b0};
        vecs[8]  = '{1'b1, 4'h0, 32'h13,   32'h0,        1'b1, 32'hDE22BE44, 1'b0};
        vecs[9]  = '{1'b1, 4'h2, 32'h12,   32'h0000AA00, 1'b1, 32'hDE22BE44, 1'b0};
        vecs[10] = '{1'b1, 4'h0, 32'h10,   32'h0,        1'b1, 32'hDE22AA44, 1'b0};
        vecs[11] = '{1'b0, 4'hF, 32'h10,   32'h0,        1'b1, 32'hDE22AA44, 1'b0};
        vecs[12] = '{1'b1, 4'h0, 32'h10,   32'h0,        1'b1, 32'hDE22AA44, 1'b0};
        vecs[13] = '{1'b1, 4'hF, 32'h0,    32'h12345678, 1'b0, 32'h0,        1'b0};
`ifdef DATA_SRAM_RESP_RANGE_CHECK_EN
        vecs[14] = '{1'b1, 4'h0, 32'h1000, 32'h0,        1'b1, 32'h0,        1'b1};
        vecs[15] = '{1'b1, 4'hF, 32'h1000, 32'hFFFFFFFF, 1'b1, 32'h0,        1'b1};
        vecs[16] = '{1'b1, 4'h0, 32'h0,    32'h0,        1'b1, 32'h12345678, 1'b0};
`else
        vecs[14] = '{1'b1, 4'h0, 32'h1000, 32'h0,        1'b1, 32'h12345678, 1'b0};
        vecs[15] = '{1'b1, 4'hF, 32'h1000, 32'hFFFFFFFF, 1'b1, 32'h12345678, 1'b0};
        vecs[16] = '{1'b1, 4'h0, 32'h0,    32'h0,        1'b1, 32'hFFFFFFFF, 1'b0};
`endif

        // reset state before any clock edge
        #1;
        check("reset_rdata", rdata, 32'h0);
        check("reset_err", {31'h0, err}, 32'h0);
        check("reset_rd_cnt", rd_cnt, 32'h0);
        check("reset_wr_cnt", wr_cnt, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // directed vector table
        for (int k = 0; k < 17; k++) begin
            do_cycle(vecs[k].en, vecs[k].wen, vecs[k].addr, vecs[k].wdata,
                     {vecs[k].chk, vecs[k].exp_err, vecs[k].exp_rd});
        end

        // asynchronous reset in the middle of a burst
        model_access(1'b1, 4'hF, 32'h40, 32'hA5A5A5A5);
        model_access(1'b1, 4'hF, 32'h44, 32'h11111111);
        en = 1'b1;
        wen = 4'hF;
        addr = 32'h40;
        wdata = 32'h0BADF00D;
        #2 rst = 1'b1;
        #1;
        check("async_rst_rdata", rdata, 32'h0);
        check("async_rst_rd_cnt", rd_cnt, 32'h0);
        check("async_rst_wr_cnt", wr_cnt, 32'h0);
        @(posedge clk);
        @(negedge clk);
        check("rst_edge_wr_cnt", wr_cnt, 32'h0);
        check("rst_edge_rdata", rdata, 32'h0);
        rst = 1'b0;
        model_reset();
        model_access(1'b1, 4'h0, 32'h40, 32'h0);
        model_access(1'b1, 4'h0, 32'h44, 32'h0);
        check("mem_survives_rst", rdata, 32'h11111111);

        // initialise words 0..15, then randomised traffic
        for (int k = 0; k < 16; k++) begin
            do_cycle(1'b1, 4'hF, 32'(k * 4), $urandom, {1'b0, 1'b0, 32'h0});
        end
        for (int k = 0; k < 16; k++) begin
            known[k] = 1'b1;
        end
        for (int k = 0; k < 200; k++) begin
            logic        e;
            logic [3:0]  w;
            logic [31:0] a;
            e = ($urandom_range(0, 3) != 0);
            w = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom_range(1, 15));
            a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            model_access(e, w, a, $urandom);
        end

        // read counter wrap
        force dut.rd_cnt = 32'hFFFFFFFE;
        #1 release dut.rd_cnt;
        rd_m = 32'hFFFFFFFE;
        model_access(1'b1, 4'h0, 32'h10, 32'h0);
        check("rd_cnt_max", rd_cnt, 32'hFFFFFFFF);
        model_access(1'b1, 4'h0, 32'h14, 32'h0);
        check("rd_cnt_wrap", rd_cnt, 32'h0);

        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
